// File: rtl/ticket_vendor_bot_one_hot.sv
// ticket_vendor_bot_one_hot
// Moore FSM for a single-ticket vending bot. The ticket costs 40. The
// customer inserts 10 and 20 bills, one per clock. Exact payment issues the
// ticket. Overpayment (30 held + 20) returns all of the money.
// The state register is one-hot. Every output is decoded straight from the
// state bits, so no input reaches an output combinationally.

module ticket_vendor_bot_one_hot (
    input  logic Clock,
    input  logic Clear,
    input  logic Ten,
    input  logic Twenty,
    output logic Ready,
    output logic Bill,
    output logic Dispense,
    output logic Return
);

    // Bit position of each state inside the one-hot register.
    localparam int unsigned READY_BIT    = 0;
    localparam int unsigned BILL10_BIT   = 1;
    localparam int unsigned BILL20_BIT   = 2;
    localparam int unsigned BILL30_BIT   = 3;
    localparam int unsigned DISPENSE_BIT = 4;
    localparam int unsigned RETURN_BIT   = 5;

    // One-hot state encodings.
    localparam logic [5:0] S_READY    = 6'b000001;
    localparam logic [5:0] S_BILL10   = 6'b000010;
    localparam logic [5:0] S_BILL20   = 6'b000100;
    localparam logic [5:0] S_BILL30   = 6'b001000;
    localparam logic [5:0] S_DISPENSE = 6'b010000;
    localparam logic [5:0] S_RETURN   = 6'b100000;

    logic [5:0] state_q;
    logic [5:0] state_d;
    logic       bill10;
    logic       bill20;

    // Decode the bill inputs. {Ten,Twenty}=11 is illegal and counts as no bill.
    assign bill10 = Ten & ~Twenty;
    assign bill20 = Twenty & ~Ten;

    // Next-state logic. Any illegal encoding (no bit set, or several bits
    // set) falls into the default branch and recovers to READY.
    always_comb begin
        // NOTE: state_d gets a value before the case statement. Every path
        // therefore assigns it, and no latch is inferred.
        state_d = S_READY;
        case (state_q)
            S_READY, S_DISPENSE, S_RETURN: begin
                // The DISPENSE and RETURN states last one cycle. A bill
                // inserted during that cycle starts the next sale at once.
                if (bill10) begin
                    state_d = S_BILL10;
                end else if (bill20) begin
                    state_d = S_BILL20;
                end else begin
                    state_d = S_READY;
                end
            end
            S_BILL10: begin
                if (bill10) begin
                    state_d = S_BILL20;
                end else if (bill20) begin
                    state_d = S_BILL30;
                end else begin
                    state_d = S_BILL10;
                end
            end
            S_BILL20: begin
                if (bill10) begin
                    state_d = S_BILL30;
                end else if (bill20) begin
                    state_d = S_DISPENSE;
                end else begin
                    state_d = S_BILL20;
                end
            end
            S_BILL30: begin
                // 30 held + 20 = 50: overpayment, so return the money.
                if (bill10) begin
                    state_d = S_DISPENSE;
                end else if (bill20) begin
                    state_d = S_RETURN;
                end else begin
                    state_d = S_BILL30;
                end
            end
            default: begin
                state_d = S_READY;
            end
        endcase
    end

    // State register. Clear is asynchronous and active-low, and it forces
    // READY immediately.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_READY;
        end else begin
            // NOTE: Sequential state uses a non-blocking assignment. All
            // flops then update together, with no race inside the simulator.
            state_q <= state_d;
        end
    end

    // Moore outputs taken from the raw state bits. If the encoding is ever
    // illegal, the outputs follow those bits until the next edge restores
    // READY.
    assign Ready    = state_q[READY_BIT];
    assign Bill     = state_q[BILL10_BIT] | state_q[BILL20_BIT] | state_q[BILL30_BIT];
    assign Dispense = state_q[DISPENSE_BIT];
    assign Return   = state_q[RETURN_BIT];

endmodule

// File: tb/tb_ticket_vendor_bot_one_hot.sv
// tb_ticket_vendor_bot_one_hot
// Scoreboard bench for the ticket vending FSM. The driver applies one bill
// per cycle and queues the output vector it expects after that edge. The
// monitor pops one entry on each falling edge and compares it with the
// outputs {Ready, Bill, Dispense, Return}.

module tb_ticket_vendor_bot_one_hot;

    // Expected output vectors, ordered {Ready, Bill, Dispense, Return}.
    localparam logic [3:0] EXP_R = 4'b1000;
    localparam logic [3:0] EXP_B = 4'b0100;
    localparam logic [3:0] EXP_D = 4'b0010;
    localparam logic [3:0] EXP_T = 4'b0001;

    typedef struct {
        logic [3:0] vec;
        string      name;
    } exp_t;

    logic Clock;
    logic Clear;
    logic Ten;
    logic Twenty;
    logic Ready;
    logic Bill;
    logic Dispense;
    logic Return;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    ticket_vendor_bot_one_hot dut (
        .Clock    (Clock),
        .Clear    (Clear),
        .Ten      (Ten),
        .Twenty   (Twenty),
        .Ready    (Ready),
        .Bill     (Bill),
        .Dispense (Dispense),
        .Return   (Return)
    );

    // Clock with a 10-unit period. Rising edges fall at 5, 15, 25, ...
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor. The outputs are valid every cycle, so one queued expectation
    // is compared on each falling edge.
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, {28'd0, Ready, Bill, Dispense, Return}, {28'd0, e.vec});
        end
    end

    // Driver step. It applies the bill inputs, queues the expected response,
    // and lets one rising edge pass. It returns just after the monitor has
    // sampled the result on the falling edge.
    task automatic step(input string name, input logic t10, input logic t20, input logic [3:0] e);
        exp_t item;
        Ten       = t10;
        Twenty    = t20;
        item.vec  = e;
        item.name = name;
        exp_q.push_back(item);
        @(posedge Clock);
        @(negedge Clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Clear  = 1'b0;
        Ten    = 1'b0;
        Twenty = 1'b0;
        @(negedge Clock);
        #1;

        // Held in reset with no bills: READY.
        step("reset_hold", 1'b0, 1'b0, EXP_R);
        Clear = 1'b1;

        // 10+10+10+10 gives Bill for three cycles, then Dispense.
        step("t4_b1", 1'b1, 1'b0, EXP_B);
        step("t4_b2", 1'b1, 1'b0, EXP_B);
        step("t4_b3", 1'b1, 1'b0, EXP_B);
        step("t4_d",  1'b1, 1'b0, EXP_D);

        // Back-to-back sales, each bill arriving in the DISPENSE cycle.
        step("ww_b",  1'b0, 1'b1, EXP_B);
        step("ww_d",  1'b0, 1'b1, EXP_D);
        step("ttw_b1", 1'b1, 1'b0, EXP_B);
        step("ttw_b2", 1'b1, 1'b0, EXP_B);
        step("ttw_d",  1'b0, 1'b1, EXP_D);
        step("wtt_b1", 1'b0, 1'b1, EXP_B);
        step("wtt_b2", 1'b1, 1'b0, EXP_B);
        step("wtt_d",  1'b1, 1'b0, EXP_D);

        // Overpayment paths end in Return, with Dispense low.
        step("tww_b1", 1'b1, 1'b0, EXP_B);
        step("tww_b2", 1'b0, 1'b1, EXP_B);
        step("tww_r",  1'b0, 1'b1, EXP_T);
        step("wtw_b1", 1'b0, 1'b1, EXP_B);
        step("wtw_b2", 1'b1, 1'b0, EXP_B);
        step("wtw_r",  1'b0, 1'b1, EXP_T);
        step("tttw_b1", 1'b1, 1'b0, EXP_B);
        step("tttw_b2", 1'b1, 1'b0, EXP_B);
        step("tttw_b3", 1'b1, 1'b0, EXP_B);
        step("tttw_r",  1'b0, 1'b1, EXP_T);

        // Idle: no bill after RETURN, then again while READY.
        step("idle_1", 1'b0, 1'b0, EXP_R);
        step("idle_2", 1'b0, 1'b0, EXP_R);

        // Hold in BILL20 for five idle cycles, then a 20 completes the sale.
        step("hold_b", 1'b0, 1'b1, EXP_B);
        for (int i = 0; i < 5; i++) begin
            step("hold_idle", 1'b0, 1'b0, EXP_B);
        end
        step("hold_d", 1'b0, 1'b1, EXP_D);

        // Input 11 is ignored, both in READY and in BILL10. Three more 10
        // bills are then needed, which shows the held amount stayed at 10.
        step("ill_rdy0", 1'b0, 1'b0, EXP_R);
        step("ill_rdy",  1'b1, 1'b1, EXP_R);
        step("ill_b10",  1'b1, 1'b0, EXP_B);
        step("ill_hold", 1'b1, 1'b1, EXP_B);
        step("ill_b20",  1'b1, 1'b0, EXP_B);
        step("ill_b30",  1'b1, 1'b0, EXP_B);
        step("ill_d",    1'b1, 1'b0, EXP_D);

        // Asynchronous clear while in BILL30, asserted between clock edges.
        step("ar_b10", 1'b1, 1'b0, EXP_B);
        step("ar_b30", 1'b0, 1'b1, EXP_B);
        Ten    = 1'b0;
        Twenty = 1'b0;
        Clear  = 1'b0;
        #1;
        check("async_clear", {28'd0, Ready, Bill, Dispense, Return}, {28'd0, EXP_R});
        #1;
        Clear = 1'b1;

        // After release, 20+20 must dispense. A stale 30 would give Return.
        step("ar_w1", 1'b0, 1'b1, EXP_B);
        step("ar_d",  1'b0, 1'b1, EXP_D);
        step("end_idle", 1'b0, 1'b0, EXP_R);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() != 0) @(negedge Clock);
        end
        check("drain", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ticket_vendor_bot_one_hot.md
# ticket_vendor_bot_one_hot

Moore state machine controlling a single-ticket vending bot. The ticket costs 40; the customer feeds 10 and 20 bills one per clock. The block dispenses on exact payment and returns the money on overpayment. State is one-hot encoded, and the block sits between the bill-acceptor front end and the dispense/return actuators.

## Interface
- No parameters. Price (40) and bill values (10, 20) are fixed.
- Clock  in  1  system clock; all state changes occur on its rising edge.
- Clear  in  1  asynchronous, active-low reset. Clear=0 forces READY immediately.
- Ten  in  1  a 10 bill is inserted this cycle.
- Twenty  in  1  a 20 bill is inserted this cycle.
- Ready  out  1  machine is idle and awaiting the first bill.
- Bill  out  1  partial payment is held; more bills are required.
- Dispense  out  1  exact payment received; ticket is issued this cycle.
- Return  out  1  overpayment received; all inserted money is returned, and no ticket is issued.

## Operation
- Six states, one-hot encoded in a 6-bit register: READY, BILL10, BILL20, BILL30, DISPENSE, RETURN.
- Bill input decode (sampled at the rising Clock edge):
  - Ten=1 with Twenty=0 is a 10 bill.
  - Ten=0 with Twenty=1 is a 20 bill.
  - 00 is no bill.
  - 11 is illegal and is treated exactly as no bill.
- Transitions:
  - READY, DISPENSE, RETURN: 10 → BILL10; 20 → BILL20; no bill → READY.
  - BILL10: 10 → BILL20; 20 → BILL30; no bill → stay.
  - BILL20: 10 → BILL30; 20 → DISPENSE; no bill → stay.
  - BILL30: 10 → DISPENSE; 20 → RETURN (total 50); no bill → stay.
- DISPENSE and RETURN each last exactly one cycle.
  - A bill presented during that cycle starts the next transaction with no idle gap.
- Outputs are decoded purely from state (Moore), one-hot, exactly one output high at any time:
  - Ready=READY.
  - Bill=BILL10|BILL20|BILL30.
  - Dispense=DISPENSE.
  - Return=RETURN.
- Illegal encodings (zero or multiple bits set) transition to READY on the next edge.
  - While the encoding is illegal, the outputs follow the raw state bits.
- No timeout: partial payment is held indefinitely while no bill arrives.

## Timing
- Reset: while Clear=0, the state is READY asynchronously, with Ready=1 and Bill=Dispense=Return=0.
- Reset release is sampled synchronously; the first transition happens at the first rising edge with Clear=1.
- Latency: a bill applied before rising edge N is reflected on the outputs after edge N (one cycle, no combinational input-to-output path).
- Exact payment paths reach DISPENSE on the edge that samples the final bill:
  - 10+10+10+10
  - 20+20
  - 10+10+20
  - 10+20+10
  - 20+10+10
- Overpayment is only possible as 30 held + 20 (10+10+20 is exact, so overpay means reaching 30 then adding 20):
  - 10+20+20
  - 20+10+20
  - 10+10+10+20
- Clear asserted mid-transaction aborts it: the state returns to READY at once and the held amount is discarded.

## Test plan
- Reset, then Ten on 4 consecutive cycles.
  - Required: Bill=1 for 3 cycles, then Dispense=1 for 1 cycle.
- Back-to-back transactions:
  - Twenty,Twenty immediately after a DISPENSE cycle → BILL20 then DISPENSE.
  - Then 10,10,20 → Bill, Bill, Dispense.
  - Then 20,10,10 → Bill, Bill, Dispense.
- Overpay:
  - 10,20,20 → Bill, Bill, Return=1 (Dispense stays 0).
  - 20,10,20 → same response.
  - 10,10,10,20 → Bill×3, then Return.
- Idle/hold:
  - {Ten,Twenty}=00 in READY → stays Ready=1.
  - 00 while in BILL20 for 5 cycles → Bill=1 held; a subsequent 20 → Dispense.
- Illegal input: {Ten,Twenty}=11 in READY and in BILL10 → state unchanged (Ready=1 / Bill=1).
- Asynchronous reset: drive Clear=0 between clock edges while in BILL30.
  - Required: Ready=1 and Bill=0 before the next rising edge.
  - After release, 20,20 → Dispense.
